// File: rtl/regfl_mp.sv
// ============================================================================
// Module   : regfl_mp
// Brief    : W x N register file, one write port, two registered read ports,
//            hardware clear sweep. Optional macro REGFL_BYPASS_EN forwards
//            same-cycle write data to a matching read port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfl_mp #(
  parameter  int W  = 13,
  parameter  int N  = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re0,
  input  logic [AW-1:0] ra0,
  output logic [W-1:0]  rd0,
  input  logic          re1,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd1,
  input  logic          clr_req,
  output logic          busy
);

  localparam logic [AW:0]   C_NUM  = N[AW:0];
  localparam logic [AW-1:0] C_LAST = AW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic          r_busy;
  logic [W-1:0]  r_mem [N];
  logic [W-1:0]  r_rd0;
  logic [W-1:0]  r_rd1;

  logic          w_wa_ok;
  logic          w_ra0_ok;
  logic          w_ra1_ok;
  logic          w_wr_acc;
  logic [W-1:0]  w_rd0;
  logic [W-1:0]  w_rd1;

  // N need not be a power of two, so every address is range-checked.
  assign w_wa_ok  = ({1'b0, wa}  < C_NUM);
  assign w_ra0_ok = ({1'b0, ra0} < C_NUM);
  assign w_ra1_ok = ({1'b0, ra1} < C_NUM);
  assign w_wr_acc = (r_state == S_IDLE) && we && w_wa_ok;

  always_comb begin
    w_rd0 = '0;
    w_rd1 = '0;
    if (w_ra0_ok) w_rd0 = r_mem[ra0];
    if (w_ra1_ok) w_rd1 = r_mem[ra1];
`ifdef REGFL_BYPASS_EN
    if (w_wr_acc && (wa == ra0)) w_rd0 = wd;
    if (w_wr_acc && (wa == ra1)) w_rd1 = wd;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_rd0   <= '0;
      r_rd1   <= '0;
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else begin
      if (re0) r_rd0 <= w_rd0;
      if (re1) r_rd1 <= w_rd1;

      case (r_state)
        S_IDLE: begin
          if (w_wr_acc) r_mem[wa] <= wd;
          if (clr_req) begin
            r_state <= S_SWEEP;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SWEEP: begin
          // Sweep clears are never forwarded; same-edge reads see old data.
          r_mem[r_ptr] <= '0;
          if (r_ptr == C_LAST) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd0  = r_rd0;
  assign rd1  = r_rd1;
  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfl_mp.sv
// ============================================================================
// Module   : tb_regfl_mp
// Brief    : Directed self-checking bench for regfl_mp (N=8 and N=6 builds).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfl_mp;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        we;
  logic [2:0]  wa;
  logic [12:0] wd;
  logic        re0;
  logic [2:0]  ra0;
  logic        re1;
  logic [2:0]  ra1;
  logic        clr_req;

  logic [12:0] rd0, rd1, rd0_6, rd1_6;
  logic        busy, busy_6;

  int checks   = 0;
  int failures = 0;

  logic [12:0] vals [8] = '{13'h11A7, 13'h1F3B, 13'h01BC, 13'h122C,
                            13'h096A, 13'h1247, 13'h0410, 13'h0FFF};
  logic [12:0] exp_v;

  always #5 clk = ~clk;

  regfl_mp #(.W(13), .N(8)) u_dut (
    .clk(clk), .rst_b(rst_b), .we(we), .wa(wa), .wd(wd),
    .re0(re0), .ra0(ra0), .rd0(rd0),
    .re1(re1), .ra1(ra1), .rd1(rd1),
    .clr_req(clr_req), .busy(busy)
  );

  regfl_mp #(.W(13), .N(6)) u_dut6 (
    .clk(clk), .rst_b(rst_b), .we(we), .wa(wa), .wd(wd),
    .re0(re0), .ra0(ra0), .rd0(rd0_6),
    .re1(re1), .ra1(ra1), .rd1(rd1_6),
    .clr_req(clr_req), .busy(busy_6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    rst_b = 1'b0; we = 1'b0; wa = '0; wd = '0;
    re0 = 1'b0; ra0 = '0; re1 = 1'b0; ra1 = '0; clr_req = 1'b0;

    // Reset
    tick(); tick();
    chk("reset_rd0", rd0, 13'h0);
    chk("reset_rd1", rd1, 13'h0);
    chk("reset_busy", {12'h0, busy}, 13'h0);
    rst_b = 1'b1;

    // Fill 0..7
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 3'(i); wd = vals[i];
      tick();
    end
    we = 1'b0;

    // Read back on both ports, port 1 in reverse order
    for (int i = 0; i < 8; i++) begin
      re0 = 1'b1; ra0 = 3'(i); re1 = 1'b1; ra1 = 3'(7 - i);
      tick();
      chk("fill_rd0", rd0, vals[i]);
      chk("fill_rd1", rd1, vals[7 - i]);
    end

    // Dual-port read then hold
    ra0 = 3'd2; ra1 = 3'd5;
    tick();
    chk("dual_rd0", rd0, 13'h01BC);
    chk("dual_rd1", rd1, 13'h1247);
    re0 = 1'b0; re1 = 1'b0; ra0 = 3'd0; ra1 = 3'd1;
    tick(); tick();
    chk("hold_rd0", rd0, 13'h01BC);
    chk("hold_rd1", rd1, 13'h1247);

    // Same-cycle read/write to address 3
    we = 1'b1; wa = 3'd3; wd = 13'h0ABC; re0 = 1'b1; ra0 = 3'd3;
    tick();
    we = 1'b0;
`ifdef REGFL_BYPASS_EN
    exp_v = 13'h0ABC;
`else
    exp_v = 13'h122C;
`endif
    chk("rw_same_cycle", rd0, exp_v);
    tick();
    chk("rw_next_cycle", rd0, 13'h0ABC);
    re0 = 1'b0;
    we = 1'b1; wa = 3'd3; wd = 13'h122C;
    tick();
    we = 1'b0;

    // Clear sweep: clr_req sampled at edge k
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("sweep_busy_k", {12'h0, busy}, 13'h1);
    re0 = 1'b1; ra0 = 3'd3; ra1 = 3'd7;
    for (int j = 1; j <= 9; j++) begin
      we  = (j == 3);
      wa  = 3'd7;
      wd  = 13'h1555;
      re1 = (j == 4) || (j == 9);
      tick();
      chk("sweep_busy", {12'h0, busy}, (j <= 7) ? 13'h1 : 13'h0);
      chk("sweep_entry3", rd0, (j <= 4) ? 13'h122C : 13'h0);
      if (j == 4) chk("sweep_wr_dropped", rd1, 13'h0FFF);
      if (j == 9) chk("sweep_entry7", rd1, 13'h0);
    end
    we = 1'b0; re0 = 1'b0; re1 = 1'b0;

    // Reset in the middle of a sweep
    we = 1'b1; wa = 3'd2; wd = 13'h0555; tick();
    wa = 3'd5; wd = 13'h1AAA; tick();
    we = 1'b0;
    clr_req = 1'b1; tick();
    clr_req = 1'b0; tick();
    rst_b = 1'b0; tick();
    rst_b = 1'b1;
    chk("midrst_busy", {12'h0, busy}, 13'h0);
    re0 = 1'b1; ra0 = 3'd5; re1 = 1'b1; ra1 = 3'd2;
    tick();
    chk("midrst_entry5", rd0, 13'h0);
    chk("midrst_entry2", rd1, 13'h0);
    re0 = 1'b0; re1 = 1'b0;
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    chk("midrst_reclr", {12'h0, busy}, 13'h1);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("reclr_busy", {12'h0, busy}, (j < 8) ? 13'h1 : 13'h0);
    end
    // Accepted on the first IDLE cycle
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    chk("first_idle_clr", {12'h0, busy}, 13'h1);
    for (int j = 1; j <= 8; j++) tick();
    chk("second_sweep_done", {12'h0, busy}, 13'h0);

    // Out-of-range addressing on the N=6 instance
    rst_b = 1'b0; tick();
    rst_b = 1'b1;
    chk("n6_reset_busy", {12'h0, busy_6}, 13'h0);
    we = 1'b1; wa = 3'd0; wd = 13'h0123; tick();
    wa = 3'd6; wd = 13'h1ABC; tick();
    we = 1'b0;
    re0 = 1'b1; ra0 = 3'd0; tick();
    chk("n6_entry0", rd0_6, 13'h0123);
    ra0 = 3'd7; re1 = 1'b1; ra1 = 3'd6; tick();
    chk("n6_oor_rd0", rd0_6, 13'h0);
    chk("n6_oor_rd1", rd1_6, 13'h0);
    chk("n8_entry6", rd1, 13'h1ABC);
    re1 = 1'b0;
    for (int i = 1; i < 6; i++) begin
      ra0 = 3'(i);
      tick();
      chk("n6_untouched", rd0_6, 13'h0);
    end
    re0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
